regfile_scoreboard: RTL and testbench

- Architectural integer register file with an in-flight write scoreboard, on the receiving end of the writeback stage.
- Consumes the writeback interface: write enable, destination address, write data.
- Serves the decode/issue stage:
  - two read ports with one-cycle registered latency;
  - same-cycle write-to-read bypass;
  - a combinational stall that blocks issue on RAW and WAW hazards against writes still in flight.

---
 rtl/regfile_scoreboard.sv | 118 +++++++++++
 tb/tb_regfile_scoreboard.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with an in-flight write scoreboard: two registered read ports with
// writeback bypass, and a combinational issue stall on RAW/WAW hazards against pending writes.
module regfile_scoreboard #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rdIssue,
  input  logic             rdValid,
  output logic             stall,
  output logic             issued,
  output logic [XLEN-1:0]  rs1Data,
  output logic [XLEN-1:0]  rs2Data,
  input  logic             writeEnabled,
  input  logic [4:0]       rdAddress,
  input  logic [XLEN-1:0]  dataIn,
  output logic [NREGS-1:0] pendingMask
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;
  logic             issued_q, issued_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;

  logic             wr;
  logic             acc;
  logic             haz_rs1, haz_rs2, haz_waw;
  logic [NREGS-1:0] wr_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] pend_eff;

  always_comb begin
    wr       = writeEnabled && (rdAddress != 5'd0);
    wr_mask  = '0;
    set_mask = '0;
    for (int i = 1; i < NREGS; i++) begin
      wr_mask[i]  = wr && (rdAddress == 5'(i));
      set_mask[i] = acc && rdValid && (rdIssue == 5'(i));
    end
    // A register retiring this cycle is no longer a hazard.
    pend_eff = pending_q & ~wr_mask;
  end

  always_comb begin
    haz_rs1 = (rs1 != 5'd0) && pend_eff[rs1];
    haz_rs2 = (rs2 != 5'd0) && pend_eff[rs2];
    haz_waw = rdValid && (rdIssue != 5'd0) && pend_eff[rdIssue];
    stall   = issue && (haz_rs1 || haz_rs2 || haz_waw);
    acc     = issue && !stall;
  end

  always_comb begin
    regs_d = regs_q;
    if (wr) begin
      regs_d[rdAddress] = dataIn;
    end
  end

  // Set wins over clear when an issue targets the register being written back.
  always_comb begin
    pending_d    = (pending_q & ~wr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    issued_d   = acc;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    if (acc) begin
      if (rs1 == 5'd0) begin
        rs1_data_d = '0;
      end else if (wr && (rdAddress == rs1)) begin
        rs1_data_d = dataIn;
      end else begin
        rs1_data_d = regs_q[rs1];
      end
      if (rs2 == 5'd0) begin
        rs2_data_d = '0;
      end else if (wr && (rdAddress == rs2)) begin
        rs2_data_d = dataIn;
      end else begin
        rs2_data_d = regs_q[rs2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pending_q  <= '0;
      issued_q   <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pending_q  <= pending_d;
      issued_q   <= issued_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  always_comb begin
    issued      = issued_q;
    rs1Data     = rs1_data_q;
    rs2Data     = rs2_data_q;
    pendingMask = pending_q;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, RAW/WAW stalls, bypass, x0, hold, back-to-back.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue;
  logic [4:0]  rs1, rs2, rdIssue;
  logic        rdValid;
  logic        stall;
  logic        issued;
  logic [31:0] rs1Data, rs2Data;
  logic        writeEnabled;
  logic [4:0]  rdAddress;
  logic [31:0] dataIn;
  logic [31:0] pendingMask;

  int checks = 0;
  int passed = 0;

  regfile_scoreboard #(
    .XLEN (32),
    .NREGS(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue       (issue),
    .rs1         (rs1),
    .rs2         (rs2),
    .rdIssue     (rdIssue),
    .rdValid     (rdValid),
    .stall       (stall),
    .issued      (issued),
    .rs1Data     (rs1Data),
    .rs2Data     (rs2Data),
    .writeEnabled(writeEnabled),
    .rdAddress   (rdAddress),
    .dataIn      (dataIn),
    .pendingMask (pendingMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic iss, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] rd, input logic rdv, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
    issue = iss; rs1 = a1; rs2 = a2; rdIssue = rd; rdValid = rdv;
    writeEnabled = we; rdAddress = wa; dataIn = wd;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 5, 0, 9, 1, 1, 5, 32'h1234);
    @(posedge clk); #1;
    checks++; if (issued !== 1'b1) $display("FAIL rst_pre_issued got %0b want 1", issued); else passed++;
    checks++; if (rs1Data !== 32'h1234) $display("FAIL rst_pre_rs1 got %h want 00001234", rs1Data); else passed++;
    checks++; if (pendingMask !== 32'h200) $display("FAIL rst_pre_pend got %h want 00000200", pendingMask); else passed++;
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 1, 6, 32'hAAAA);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pendingMask !== 32'h0) $display("FAIL rst_pend got %h want 0", pendingMask); else passed++;
    checks++; if (rs1Data !== 32'h0) $display("FAIL rst_rs1 got %h want 0", rs1Data); else passed++;
    checks++; if (rs2Data !== 32'h0) $display("FAIL rst_rs2 got %h want 0", rs2Data); else passed++;
    checks++; if (issued !== 1'b0) $display("FAIL rst_issued got %0b want 0", issued); else passed++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 5, 6, 0, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    checks++; if (rs1Data !== 32'h0) $display("FAIL rst_x5_cleared got %h want 0", rs1Data); else passed++;
    checks++; if (rs2Data !== 32'h0) $display("FAIL rst_x6_not_written got %h want 0", rs2Data); else passed++;
    checks++; if (issued !== 1'b1) $display("FAIL rst_post_issued got %0b want 1", issued); else passed++;
  endtask

  task automatic test_raw();
    @(negedge clk);
    set_in(1, 0, 0, 3, 1, 0, 0, 32'h0);
    @(posedge clk); #1;
    checks++; if (pendingMask !== 32'h8) $display("FAIL raw_set got %h want 00000008", pendingMask); else passed++;
    @(negedge clk);
    set_in(1, 3, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL raw_stall got %0b want 1", stall); else passed++;
    @(posedge clk); #1;
    checks++; if (issued !== 1'b0) $display("FAIL raw_issued_low got %0b want 0", issued); else passed++;
    @(negedge clk);
    set_in(1, 3, 0, 0, 0, 1, 3, 32'hDEADBEEF);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL raw_release got %0b want 0", stall); else passed++;
    @(posedge clk); #1;
    checks++; if (issued !== 1'b1) $display("FAIL raw_issued got %0b want 1", issued); else passed++;
    checks++; if (rs1Data !== 32'hDEADBEEF) $display("FAIL raw_bypass got %h want deadbeef", rs1Data); else passed++;
    checks++; if (pendingMask !== 32'h0) $display("FAIL raw_clear got %h want 0", pendingMask); else passed++;
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    checks++; if (issued !== 1'b0) $display("FAIL raw_idle_issued got %0b want 0", issued); else passed++;
  endtask

  task automatic test_waw();
    @(negedge clk);
    set_in(1, 0, 0, 7, 1, 0, 0, 32'h0);
    @(posedge clk); #1;
    checks++; if (pendingMask !== 32'h80) $display("FAIL waw_set got %h want 00000080", pendingMask); else passed++;
    @(negedge clk);
    set_in(1, 0, 0, 7, 1, 0, 0, 32'h0);
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL waw_stall got %0b want 1", stall); else passed++;
    @(posedge clk); #1;
    checks++; if (issued !== 1'b0) $display("FAIL waw_issued_low got %0b want 0", issued); else passed++;
    @(negedge clk);
    set_in(1, 0, 0, 7, 1, 1, 7, 32'h77);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL waw_release got %0b want 0", stall); else passed++;
    @(posedge clk); #1;
    checks++; if (issued !== 1'b1) $display("FAIL waw_issued got %0b want 1", issued); else passed++;
    checks++; if (pendingMask !== 32'h80) $display("FAIL waw_set_wins got %h want 00000080", pendingMask); else passed++;
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 1, 7, 32'h700);
    @(posedge clk); #1;
    checks++; if (pendingMask !== 32'h0) $display("FAIL waw_drain got %h want 0", pendingMask); else passed++;
  endtask

  task automatic test_x0();
    @(negedge clk);
    set_in(1, 0, 0, 0, 1, 1, 0, 32'hFFFFFFFF);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL x0_stall got %0b want 0", stall); else passed++;
    @(posedge clk); #1;
    checks++; if (rs1Data !== 32'h0) $display("FAIL x0_rs1 got %h want 0", rs1Data); else passed++;
    checks++; if (rs2Data !== 32'h0) $display("FAIL x0_rs2 got %h want 0", rs2Data); else passed++;
    checks++; if (pendingMask !== 32'h0) $display("FAIL x0_pend got %h want 0", pendingMask); else passed++;
    @(negedge clk);
    set_in(1, 0, 0, 0, 1, 0, 0, 32'h0);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL x0_rd_stall got %0b want 0", stall); else passed++;
  endtask

  task automatic test_hold();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 1, 2, 32'h55);
    @(posedge clk);
    @(negedge clk);
    set_in(1, 2, 0, 4, 1, 0, 0, 32'h0);
    @(posedge clk); #1;
    checks++; if (rs1Data !== 32'h55) $display("FAIL hold_read got %h want 00000055", rs1Data); else passed++;
    checks++; if (issued !== 1'b1) $display("FAIL hold_issued got %0b want 1", issued); else passed++;
    @(negedge clk);
    set_in(1, 4, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL hold_stall got %0b want 1", stall); else passed++;
    @(posedge clk); #1;
    checks++; if (rs1Data !== 32'h55) $display("FAIL hold_data got %h want 00000055", rs1Data); else passed++;
    checks++; if (issued !== 1'b0) $display("FAIL hold_issued_low got %0b want 0", issued); else passed++;
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 1, 4, 32'h44);
    @(posedge clk); #1;
    checks++; if (pendingMask !== 32'h0) $display("FAIL hold_drain got %h want 0", pendingMask); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rds [3];
    logic [31:0] set_exp [3];
    logic [31:0] clr_exp [3];
    rds = '{5'd1, 5'd2, 5'd4};
    set_exp = '{32'h2, 32'h6, 32'h16};
    clr_exp = '{32'h14, 32'h10, 32'h0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(1, 0, 0, rds[i], 1, 0, 0, 32'h0);
      @(posedge clk); #1;
      checks++;
      if (pendingMask !== set_exp[i])
        $display("FAIL b2b_set%0d got %h want %h", i, pendingMask, set_exp[i]);
      else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 1, rds[i], 32'h11 * {27'd0, rds[i]});
      @(posedge clk); #1;
      checks++;
      if (pendingMask !== clr_exp[i])
        $display("FAIL b2b_clr%0d got %h want %h", i, pendingMask, clr_exp[i]);
      else passed++;
    end
    @(negedge clk);
    set_in(1, 1, 2, 0, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    checks++; if (rs1Data !== 32'h11) $display("FAIL b2b_x1 got %h want 00000011", rs1Data); else passed++;
    checks++; if (rs2Data !== 32'h22) $display("FAIL b2b_x2 got %h want 00000022", rs2Data); else passed++;
    @(negedge clk);
    set_in(1, 4, 0, 0, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    checks++; if (rs1Data !== 32'h44) $display("FAIL b2b_x4 got %h want 00000044", rs1Data); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    test_reset();
    test_raw();
    test_waw();
    test_x0();
    test_hold();
    test_back_to_back();
    @(negedge clk);
    idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
